// File: rtl/jellyvl_etherneco_packet_tx_if.sv
// Byte-stream valid/ready bundle used for the payload source and the frame output.
// first/last are meaningful on the frame side only.
interface jellyvl_etherneco_packet_tx_if;
  logic       first;
  logic       last;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output first, last, data, valid,
    input  ready
  );

  modport slave (
    input  first, last, data, valid,
    output ready
  );
endinterface

// File: rtl/jellyvl_etherneco_packet_tx.sv
// Etherneco frame generator: preamble, LENGTH/TYPE/NODE header, streamed
// payload and Ethernet FCS, emitted through a registered output slot.
module jellyvl_etherneco_packet_tx #(
  parameter int GAP_CYCLES = 12
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        tx_start,
  input  logic [15:0] tx_length,
  input  logic [7:0]  tx_type,
  input  logic [7:0]  tx_node,
  output logic        tx_busy,
  jellyvl_etherneco_packet_tx_if.slave  s_payload,
  jellyvl_etherneco_packet_tx_if.master m_tx
);

  typedef enum logic [2:0] {
    IDLE, PRE, LEN, TYP, NOD, PAY, FCS, GAP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] pos, pos_n;
  logic [15:0] gap, gap_n;
  logic [15:0] len;
  logic [7:0]  typ;
  logic [7:0]  node;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        slot_free;
  logic        ld, ld_first, ld_last;
  logic [7:0]  ld_data;
  logic        crc_en, crc_upd;

  // Bit-reflected form of POLY 0x04C11DB7, data LSB first (Ethernet order).
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  assign tx_busy = (state != IDLE);

  always_comb begin
    slot_free       = !m_tx.valid || m_tx.ready;
    fcs             = ~crc;
    state_n         = state;
    cnt_n           = cnt;
    pos_n           = pos;
    gap_n           = gap;
    ld              = 1'b0;
    ld_first        = 1'b0;
    ld_last         = 1'b0;
    ld_data         = 8'h00;
    crc_en          = 1'b0;
    crc_upd         = 1'b1;
    s_payload.ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          ld       = 1'b1;
          ld_first = 1'b1;
          ld_data  = 8'h55;
          cnt_n    = 4'd1;
          state_n  = PRE;
        end
      end
      PRE: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = (cnt == 4'd7) ? 8'hD5 : 8'h55;
          if (cnt == 4'd7) begin
            cnt_n   = 4'd0;
            state_n = LEN;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      LEN: begin
        if (slot_free) begin
          ld      = 1'b1;
          crc_en  = 1'b1;
          crc_upd = (cnt != 4'd0);
          ld_data = (cnt == 4'd0) ? len[7:0] : len[15:8];
          if (cnt == 4'd1) begin
            cnt_n   = 4'd0;
            state_n = TYP;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      TYP: begin
        if (slot_free) begin
          ld      = 1'b1;
          crc_en  = 1'b1;
          ld_data = typ;
          state_n = NOD;
        end
      end
      NOD: begin
        if (slot_free) begin
          ld      = 1'b1;
          crc_en  = 1'b1;
          ld_data = node;
          pos_n   = 16'd0;
          state_n = PAY;
        end
      end
      PAY: begin
        s_payload.ready = slot_free;
        if (slot_free && s_payload.valid) begin
          ld      = 1'b1;
          crc_en  = 1'b1;
          ld_data = s_payload.data;
          if (pos == len) begin
            cnt_n   = 4'd0;
            state_n = FCS;
          end else begin
            pos_n = pos + 16'd1;
          end
        end
      end
      FCS: begin
        if (slot_free) begin
          if (cnt < 4'd4) begin
            ld      = 1'b1;
            ld_data = fcs[{cnt[1:0], 3'b000} +: 8];
            ld_last = (cnt == 4'd3);
            cnt_n   = cnt + 4'd1;
          end else begin
            // cnt==4 with a free slot is the last-byte handshake.
            gap_n   = 16'd0;
            state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        gap_n = gap + 16'd1;
        if (gap == 16'(GAP_CYCLES - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pos        <= 16'd0;
      gap        <= 16'd0;
      m_tx.valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pos   <= pos_n;
      gap   <= gap_n;
      if (slot_free) m_tx.valid <= ld;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && tx_start) begin
      len  <= tx_length;
      typ  <= tx_type;
      node <= tx_node;
    end
    if (slot_free && ld) begin
      m_tx.first <= ld_first;
      m_tx.last  <= ld_last;
      m_tx.data  <= ld_data;
    end
    if (crc_en) crc <= crc_byte(crc_upd ? crc : 32'hFFFF_FFFF, ld_data);
  end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_tx.sv
// Bench for jellyvl_etherneco_packet_tx: random payloads and backpressure
// compared against a software frame builder and MSB-first CRC-32 model.
module tb_jellyvl_etherneco_packet_tx;
  localparam int GAP = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_start = 1'b0;
  logic [15:0] tx_length = 16'd0;
  logic [7:0]  tx_type = 8'd0;
  logic [7:0]  tx_node = 8'd0;
  logic        tx_busy;

  jellyvl_etherneco_packet_tx_if s_payload ();
  jellyvl_etherneco_packet_tx_if m_tx ();

  jellyvl_etherneco_packet_tx #(.GAP_CYCLES(GAP)) dut (
    .reset(reset), .clk(clk),
    .tx_start(tx_start), .tx_length(tx_length),
    .tx_type(tx_type), .tx_node(tx_node), .tx_busy(tx_busy),
    .s_payload(s_payload), .m_tx(m_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] pl_q[$];
  int   pl_idx = 0, valid_pct = 100, ready_pct = 100;
  logic pl_hs = 1'b0;
  logic [9:0] rx_q[$], exp_q[$];
  int   last_cnt = 0, hold_err = 0, last_cyc = 0, gap_seen = -1, busy_fall = -1;
  logic pend = 1'b0, busy_prev = 1'b0;
  logic [9:0] held, cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload source and downstream ready; valid is held until accepted.
  initial begin
    s_payload.valid = 1'b0; s_payload.data = 8'h00;
    s_payload.first = 1'b0; s_payload.last = 1'b0;
    m_tx.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pl_hs) pl_idx++;
      if (!s_payload.valid || pl_hs) begin
        s_payload.valid = (pl_idx < pl_q.size()) && ($urandom_range(99) < valid_pct);
        s_payload.data  = (pl_idx < pl_q.size()) ? pl_q[pl_idx] : 8'h00;
      end
      m_tx.ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor: collects handshaked bytes, checks hold stability.
  initial forever begin
    @(negedge clk);
    pl_hs = s_payload.valid && s_payload.ready && !reset;
    if (reset) begin
      pend = 1'b0;
    end else begin
      cur = {m_tx.first, m_tx.last, m_tx.data};
      if (pend && (!m_tx.valid || cur !== held)) hold_err++;
      if (m_tx.valid && m_tx.first && !pend) gap_seen = cyc - last_cyc - 1;
      if (m_tx.valid && m_tx.ready) begin
        rx_q.push_back(cur);
        if (m_tx.last) begin
          last_cnt++;
          last_cyc = cyc;
        end
      end
      pend = m_tx.valid && !m_tx.ready;
      held = cur;
      if (busy_prev && !tx_busy) busy_fall = cyc;
    end
    busy_prev = tx_busy;
  end

  // Non-reflected CRC-32 run on bit-reversed bytes, result reflected and inverted.
  function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
    logic [31:0] r = 32'hFFFF_FFFF;
    logic [7:0]  b;
    foreach (q[k]) begin
      for (int j = 0; j < 8; j++) b[j] = q[k][7-j];
      r = r ^ {b, 24'h0};
      for (int j = 0; j < 8; j++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    end
    return ~{<<{r}};
  endfunction

  task automatic add_frame(input logic [15:0] l, input logic [7:0] t, input logic [7:0] n,
                           input int off);
    logic [7:0]  body[$];
    logic [31:0] c;
    body = {l[7:0], l[15:8], t, n};
    for (int i = 0; i <= int'(l); i++) body.push_back(pl_q[off+i]);
    c = crc_model(body);
    for (int k = 0; k < 4; k++) body.push_back(c[8*k +: 8]);
    for (int i = 0; i < 7; i++) exp_q.push_back({(i == 0), 1'b0, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
    foreach (body[i]) exp_q.push_back({1'b0, (i == body.size() - 1), body[i]});
  endtask

  function automatic logic [31:0] residue(input int n);
    logic [7:0] b[$];
    for (int i = 8; i < n; i++) b.push_back(rx_q[i][7:0]);
    return crc_model(b);
  endfunction

  task automatic setup(input int nbytes, input int vp, input int rp);
    @(posedge clk); #2;
    pl_q.delete();
    for (int i = 0; i < nbytes; i++) pl_q.push_back(8'($urandom));
    pl_idx = 0; pl_hs = 1'b0; s_payload.valid = 1'b0;
    valid_pct = vp; ready_pct = rp;
    rx_q.delete(); exp_q.delete();
    last_cnt = 0; hold_err = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, tx_busy, 1'b0);
  endtask

  task automatic start(input string tag, input logic [15:0] l, input logic [7:0] t,
                       input logic [7:0] n);
    wait_idle(tag);
    @(posedge clk); #2;
    tx_start = 1'b1; tx_length = l; tx_type = t; tx_node = n;
    @(posedge clk); #2;
    tx_start = 1'b0;
    @(negedge clk);
    chk({tag, "_acc_busy"}, tx_busy, 1'b1);
    chk({tag, "_acc_first"}, {m_tx.valid, m_tx.first, m_tx.data}, {2'b11, 8'h55});
  endtask

  task automatic wait_last(input string tag, input int target, input int budget);
    int n = 0;
    while (last_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done"}, (last_cnt >= target), 1'b1);
  endtask

  task automatic compare(input string tag);
    int bad = 0, at = -1;
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        if (at < 0) at = i;
      end
    end
    chk($sformatf("%s_bytes_bad_from_%0d", tag, at), bad, 0);
    chk({tag, "_hold"}, hold_err, 0);
  endtask

  initial begin
    logic [7:0] t1, t2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_valid", m_tx.valid, 1'b0);
    chk("rst_pready", s_payload.ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;

    // 1: fixed 4-byte frame, then inter-frame gap timing
    setup(4, 100, 100);
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    add_frame(16'd3, 8'h10, 8'h00, 0);
    start("t1", 16'd3, 8'h10, 8'h00);
    wait_last("t1", 1, 200);
    compare("t1");
    chk("t1_residue", residue(rx_q.size()), 32'h2144_DF1C);
    chk("t1_consumed", pl_idx, 4);
    wait_idle("t1");
    chk("t1_busy_fall", busy_fall - last_cyc, GAP + 1);

    // 2: single-byte payload, extra source bytes must stay unconsumed
    setup(4, 100, 100);
    pl_q[0] = 8'hAA;
    add_frame(16'd0, 8'h21, 8'h05, 0);
    start("t2", 16'd0, 8'h21, 8'h05);
    wait_last("t2", 1, 200);
    compare("t2");
    chk("t2_residue", residue(rx_q.size()), 32'h2144_DF1C);
    repeat (5) @(negedge clk);
    chk("t2_consumed", pl_idx, 1);

    // 3: random backpressure and payload bubbles
    setup(70, 60, 50);
    t1 = 8'($urandom);
    add_frame(16'd63, t1, 8'h3C, 0);
    start("t3", 16'd63, t1, 8'h3C);
    wait_last("t3", 1, 3000);
    compare("t3");
    chk("t3_residue", residue(rx_q.size()), 32'h2144_DF1C);
    chk("t3_consumed", pl_idx, 64);

    // 4: tx_start held high; fields changed mid-frame only affect the next frame
    setup(33, 100, 100);
    t1 = 8'($urandom); t2 = 8'($urandom);
    add_frame(16'd20, t1, 8'h11, 0);
    add_frame(16'd9, t2, 8'h22, 21);
    wait_idle("t4");
    @(posedge clk); #2;
    tx_start = 1'b1; tx_length = 16'd20; tx_type = t1; tx_node = 8'h11;
    repeat (3) @(posedge clk);
    #2;
    tx_length = 16'd9; tx_type = t2; tx_node = 8'h22;
    wait_last("t4", 2, 400);
    @(posedge clk); #2;
    tx_start = 1'b0;
    compare("t4");
    chk("t4_gap_min", (gap_seen >= GAP), 1'b1);
    chk("t4_gap_max", (gap_seen <= GAP + 1), 1'b1);
    chk("t4_consumed", pl_idx, 31);

    // 5: reset in the middle of the payload, then a clean L=2 frame
    setup(110, 100, 100);
    start("t5a", 16'd100, 8'h55, 8'h01);
    for (int n = 0; n < 200 && rx_q.size() < 40; n++) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_valid", m_tx.valid, 1'b0);
    chk("t5_rst_busy", tx_busy, 1'b0);
    chk("t5_rst_pready", s_payload.ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    setup(5, 100, 100);
    add_frame(16'd2, 8'h7E, 8'h09, 0);
    start("t5b", 16'd2, 8'h7E, 8'h09);
    wait_last("t5b", 1, 200);
    compare("t5b");
    chk("t5_residue", residue(rx_q.size()), 32'h2144_DF1C);

    // 6: maximum length frame
    setup(65538, 100, 100);
    add_frame(16'hFFFF, 8'hC3, 8'h0F, 0);
    start("t6", 16'hFFFF, 8'hC3, 8'h0F);
    wait_last("t6", 1, 70000);
    repeat (4) @(negedge clk);
    compare("t6");
    chk("t6_last_once", last_cnt, 1);
    chk("t6_residue", residue(rx_q.size()), 32'h2144_DF1C);
    chk("t6_consumed", pl_idx, 65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
